cu_sequencer: RTL and testbench

- Control-unit sequence register that sits directly upstream of the combinational control-signal decoder.
- Holds the current micro-step (0..39) and drives it as the one-hot CPU_state vector that the decoder turns into register loads, ALUSEL and SYSTEMBUSSEL.
- Consumes the decoder's COUNTER_LD/COUNTER_INC/COUNTER_CLR, the IR opcode field and the NZCV flags.
- On COUNTER_LD, maps the opcode to its routine start state, resolving conditional branches here.

---
 rtl/cu_sequencer.sv | 138 +++++++++++++
 tb/tb_cu_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// Control-unit micro-step sequencer: binary state index register with one-hot CPU_state decode,
// opcode dispatch and branch resolution. Optional ILLEGAL_TRAP_EN halts the CPU on illegal opcodes.
module cu_sequencer #(
  parameter int states = 40,
  parameter int OPW    = 5,
  parameter int IDXW   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              COUNTER_LD,
  input  logic              COUNTER_INC,
  input  logic              COUNTER_CLR,
  input  logic [OPW-1:0]    OPCODE,
  input  logic [3:0]        NZCV,
  output logic [states-1:0] CPU_state,
  output logic [IDXW-1:0]   STATE_IDX,
  output logic              ILLEGAL
);

  localparam logic [IDXW-1:0] S_FETCH1 = IDXW'(0);
  localparam logic [IDXW-1:0] S_NOP1   = IDXW'(3);
  localparam logic [IDXW-1:0] S_MOV    = IDXW'(4);
  localparam logic [IDXW-1:0] S_AMOV   = IDXW'(5);
  localparam logic [IDXW-1:0] S_LDR    = IDXW'(7);
  localparam logic [IDXW-1:0] S_ALDR   = IDXW'(9);
  localparam logic [IDXW-1:0] S_STR    = IDXW'(13);
  localparam logic [IDXW-1:0] S_ASTR   = IDXW'(17);
  localparam logic [IDXW-1:0] S_CMP    = IDXW'(21);
  localparam logic [IDXW-1:0] S_B      = IDXW'(22);
  localparam logic [IDXW-1:0] S_BGT    = IDXW'(23);
  localparam logic [IDXW-1:0] S_BLT    = IDXW'(24);
  localparam logic [IDXW-1:0] S_BEQ    = IDXW'(25);
  localparam logic [IDXW-1:0] S_ADD    = IDXW'(26);
  localparam logic [IDXW-1:0] S_SUB    = IDXW'(28);
  localparam logic [IDXW-1:0] S_MUL    = IDXW'(30);
  localparam logic [IDXW-1:0] S_LSR    = IDXW'(32);
  localparam logic [IDXW-1:0] S_AND    = IDXW'(34);
  localparam logic [IDXW-1:0] S_OR     = IDXW'(36);
  localparam logic [IDXW-1:0] S_MVN    = IDXW'(38);
  localparam logic [IDXW-1:0] S_LAST   = IDXW'(states - 1);

  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ld_target;
  logic            ld_illegal;
  logic            flag_n, flag_z, flag_v;
  logic            unused_carry;

  assign flag_n = NZCV[3];
  assign flag_z = NZCV[2];
  assign flag_v = NZCV[0];
  // Carry takes no part in any condition resolved here.
  assign unused_carry = NZCV[1];

  // Routine start state for the current opcode; untaken branches fall into nop1.
  always_comb begin
    ld_target  = S_FETCH1;
    ld_illegal = 1'b0;
    case (int'(OPCODE))
      0:  ld_target = S_NOP1;
      1:  ld_target = S_MOV;
      2:  ld_target = S_AMOV;
      3:  ld_target = S_LDR;
      4:  ld_target = S_ALDR;
      5:  ld_target = S_STR;
      6:  ld_target = S_ASTR;
      7:  ld_target = S_CMP;
      8:  ld_target = S_B;
      9:  ld_target = (!flag_z && (flag_n == flag_v)) ? S_BGT : S_NOP1;
      10: ld_target = (flag_n != flag_v) ? S_BLT : S_NOP1;
      11: ld_target = flag_z ? S_BEQ : S_NOP1;
      12: ld_target = S_ADD;
      13: ld_target = S_SUB;
      14: ld_target = S_MUL;
      15: ld_target = S_LSR;
      16: ld_target = S_AND;
      17: ld_target = S_OR;
      18: ld_target = S_MVN;
      default: begin
        ld_target  = S_FETCH1;
        ld_illegal = 1'b1;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    idx_d     = idx_q;
    illegal_d = illegal_q;
    if (idx_q > S_LAST || illegal_q) begin
      idx_d = S_FETCH1;
    end else if (COUNTER_CLR) begin
      idx_d = S_FETCH1;
    end else if (COUNTER_LD) begin
      idx_d     = ld_target;
      illegal_d = ld_illegal;
    end else if (COUNTER_INC) begin
      idx_d = (idx_q == S_LAST) ? S_FETCH1 : idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign ILLEGAL = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = ld_illegal;

  always_comb begin
    idx_d = idx_q;
    if (idx_q > S_LAST) begin
      idx_d = S_FETCH1;
    end else if (COUNTER_CLR) begin
      idx_d = S_FETCH1;
    end else if (COUNTER_LD) begin
      idx_d = ld_target;
    end else if (COUNTER_INC) begin
      idx_d = (idx_q == S_LAST) ? S_FETCH1 : idx_q + IDXW'(1);
    end
  end

  assign ILLEGAL = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) idx_q <= S_FETCH1;
    else     idx_q <= idx_d;
  end

  assign STATE_IDX = idx_q;
  assign CPU_state = {{(states-1){1'b0}}, 1'b1} << idx_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed plan steps followed by random control traffic,
// all compared against a table-driven reference model of the micro-step rules.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        COUNTER_LD = 1'b0, COUNTER_INC = 1'b0, COUNTER_CLR = 1'b0;
  logic [4:0]  OPCODE = '0;
  logic [3:0]  NZCV = '0;
  logic [39:0] CPU_state;
  logic [5:0]  STATE_IDX;
  logic        ILLEGAL;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_idx = 0;
  bit m_ill = 1'b0;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  int start_tbl [0:18] = '{3, 4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 26, 28, 30, 32, 34, 36, 38};

  cu_sequencer #(.states(40), .OPW(5), .IDXW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .COUNTER_LD (COUNTER_LD),
    .COUNTER_INC(COUNTER_INC),
    .COUNTER_CLR(COUNTER_CLR),
    .OPCODE     (OPCODE),
    .NZCV       (NZCV),
    .CPU_state  (CPU_state),
    .STATE_IDX  (STATE_IDX),
    .ILLEGAL    (ILLEGAL)
  );

  always #5 clk = ~clk;

  function automatic int branch_target(input int opc, input logic [3:0] f);
    bit n, z, v, taken;
    n = f[3]; z = f[2]; v = f[0];
    case (opc)
      9:       taken = !z && (n == v);
      10:      taken = (n != v);
      11:      taken = z;
      default: taken = 1'b1;
    endcase
    return taken ? start_tbl[opc] : 3;
  endfunction

  task automatic model_update(input bit r, input bit clr, input bit ld, input bit inc,
                              input int opc, input logic [3:0] f);
    if (r) begin
      m_idx = 0;
      m_ill = 1'b0;
    end else if (TRAP && m_ill) begin
      m_idx = 0;
    end else if (clr) begin
      m_idx = 0;
    end else if (ld) begin
      if (opc <= 18) begin
        m_idx = branch_target(opc, f);
      end else begin
        m_idx = 0;
        if (TRAP) m_ill = 1'b1;
      end
    end else if (inc) begin
      m_idx = (m_idx + 1) % 40;
    end
  endtask

  task automatic check(input string tag);
    logic [39:0] exp_oh;
    logic [5:0]  exp_idx;
    exp_oh  = 40'b1 << m_idx;
    exp_idx = 6'(m_idx);
    n_checks++;
    assert (STATE_IDX === exp_idx) n_pass++;
    else $error("FAIL %s STATE_IDX: got %0d expected %0d", tag, STATE_IDX, exp_idx);
    n_checks++;
    assert (CPU_state === exp_oh) n_pass++;
    else $error("FAIL %s CPU_state: got %h expected %h", tag, CPU_state, exp_oh);
    n_checks++;
    assert ($onehot(CPU_state)) n_pass++;
    else $error("FAIL %s onehot: got %h expected a single set bit", tag, CPU_state);
    n_checks++;
    assert (ILLEGAL === m_ill) n_pass++;
    else $error("FAIL %s ILLEGAL: got %b expected %b", tag, ILLEGAL, m_ill);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input bit r, input bit clr, input bit ld, input bit inc,
                      input int opc, input logic [3:0] f, input string tag);
    rst = r; COUNTER_CLR = clr; COUNTER_LD = ld; COUNTER_INC = inc;
    OPCODE = 5'(opc); NZCV = f;
    model_update(r, clr, ld, inc, opc, f);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    // Reset for two cycles, then idle
    step(1, 0, 0, 0, 0, 4'h0, "reset0");
    step(1, 0, 0, 0, 0, 4'h0, "reset1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 4'h0, "reset_hold");

    // Fetch/dispatch
    step(0, 0, 0, 1, 0,  4'h0, "fetch_inc1");
    step(0, 0, 0, 1, 0,  4'h0, "fetch_inc2");
    step(0, 0, 1, 0, 12, 4'h0, "ld_add");
    step(0, 0, 0, 1, 0,  4'h0, "add_inc");
    step(0, 1, 0, 0, 0,  4'h0, "clr");

    // Branch resolution
    step(0, 0, 1, 0, 11, 4'b0100, "beq_taken");
    step(0, 0, 1, 0, 11, 4'b0000, "beq_not_taken");
    step(0, 0, 1, 0, 9,  4'b1001, "bgt_taken");
    step(0, 0, 1, 0, 10, 4'b1001, "blt_not_taken");
    step(0, 0, 1, 0, 10, 4'b1000, "blt_taken");
    step(0, 0, 1, 0, 9,  4'b0100, "bgt_z_not_taken");

    // Priority and wrap
    step(0, 0, 1, 0, 6, 4'h0, "ld_astr");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 4'h0, "inc_to_20");
    step(0, 1, 1, 1, 12, 4'h0, "clr_ld_inc");
    step(0, 0, 1, 1, 5,  4'h0, "ld_over_inc");
    step(0, 0, 1, 0, 18, 4'h0, "ld_mvn");
    step(0, 0, 0, 1, 0,  4'h0, "inc_to_39");
    step(0, 0, 0, 1, 0,  4'h0, "wrap_39");
    step(0, 0, 1, 0, 6,  4'h0, "ld_17");
    step(0, 0, 0, 0, 0,  4'h0, "hold_17");
    step(0, 0, 0, 0, 3,  4'hF, "hold_17_again");

    // Illegal opcode
    step(0, 0, 0, 1, 0,  4'h0, "ill_inc1");
    step(0, 0, 0, 1, 0,  4'h0, "ill_inc2");
    step(0, 0, 1, 0, 25, 4'h0, "ld_illegal");
    step(0, 0, 0, 1, 0,  4'h0, "after_ill_inc");
    step(0, 0, 1, 0, 12, 4'h0, "after_ill_ld");
    step(1, 0, 0, 0, 0,  4'h0, "ill_reset");

    // Mid-routine reset
    step(0, 0, 1, 0, 6, 4'h0, "mid_ld");
    step(0, 0, 0, 1, 0, 4'h0, "mid_inc");
    step(1, 0, 0, 1, 0, 4'h0, "mid_rst_inc");
    step(0, 0, 0, 0, 0, 4'h0, "post_rst_hold");

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      bit r, clr, ld, inc;
      r   = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 7) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      inc = ($urandom_range(0, 1) == 1);
      step(r, clr, ld, inc, int'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
